// File: rtl/uart_rx_os_if.sv
// Receive-side bus of the oversampling UART: serial line in, byte handshake and status out.
interface uart_rx_os_if;
    logic       rx;
    logic       rd_en;
    logic [7:0] dout;
    logic       rd_rdy;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    modport master (
        output rx, rd_en,
        input  dout, rd_rdy, frame_err, overrun, busy
    );

    modport slave (
        input  rx, rd_en,
        output dout, rd_rdy, frame_err, overrun, busy
    );
endinterface

// File: rtl/uart_rx_os.sv
// Oversampling 8N1 UART receiver with rd_en/rd_rdy byte handshake,
// framing-error and overrun pulses.
module uart_rx_os #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic         clk,
    input  logic         rst,
    uart_rx_os_if.slave  bus
);
    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_MID  = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAITHI
    } state_e;

    state_e        state_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    bit_q;
    logic [7:0]    shift_q;
    logic          sync1_q;
    logic          sync2_q;
    logic [7:0]    dout_q;
    logic          rd_rdy_q;
    logic          frame_err_q;
    logic          overrun_q;
    logic          busy_q;

    logic rx_s;
    logic done_c;

    assign rx_s   = sync2_q;
    // A good stop bit is being sampled this cycle.
    assign done_c = (state_q == S_STOP) && (cnt_q == CNT_LAST) && rx_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            dout_q      <= '0;
            rd_rdy_q    <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            sync1_q     <= bus.rx;
            sync2_q     <= sync1_q;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (!rx_s) begin
                        state_q <= S_START;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                S_START: begin
                    if (cnt_q == CNT_MID) begin
                        if (!rx_s) begin
                            state_q <= S_DATA;
                            cnt_q   <= '0;
                            bit_q   <= '0;
                        end else begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_DATA: begin
                    if (cnt_q == CNT_LAST) begin
                        shift_q[bit_q] <= rx_s;
                        cnt_q          <= '0;
                        if (bit_q == 3'd7) begin
                            state_q <= S_STOP;
                        end else begin
                            bit_q <= bit_q + 3'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_STOP: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q <= '0;
                        if (rx_s) begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= S_WAITHI;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_WAITHI: begin
                    // Line break: wait for the line to return high before re-arming.
                    if (rx_s) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase

            // A read in the completion cycle frees the slot for the new byte.
            if (done_c) begin
                if (!rd_rdy_q || bus.rd_en) begin
                    dout_q   <= shift_q;
                    rd_rdy_q <= 1'b1;
                end else begin
                    overrun_q <= 1'b1;
                end
            end else if (rd_rdy_q && bus.rd_en) begin
                rd_rdy_q <= 1'b0;
            end
        end
    end

    assign bus.dout      = dout_q;
    assign bus.rd_rdy    = rd_rdy_q;
    assign bus.frame_err = frame_err_q;
    assign bus.overrun   = overrun_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os: frame table plus hand sequences for false start,
// line break and mid-frame reset.
module tb_uart_rx_os;
    localparam int unsigned CPB = 16;
    localparam int FRAME_CLKS = 10 * CPB;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    int   fe_cnt;
    int   ov_cnt;

    uart_rx_os_if bus ();

    uart_rx_os #(.CLKS_PER_BIT(CPB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters, sampled away from the active edge.
    always @(negedge clk) begin
        if (bus.frame_err === 1'b1) fe_cnt++;
        if (bus.overrun === 1'b1) ov_cnt++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         rden_at;
        int         gap;
        logic [7:0] exp_dout;
        logic       exp_rdy;
        int         exp_fe;
        int         exp_ov;
        logic       do_read;
    } vec_t;

    localparam int NV = 8;
    vec_t vec [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic frame_bit(input logic [7:0] d, input logic stop, input int i);
        int idx;
        idx = i / CPB;
        if (idx == 0) return 1'b0;
        if (idx <= 8) return d[idx-1];
        return stop;
    endfunction

    // One 8N1 frame starting now (a negedge); rd_en pulses at clk offset rden_at.
    task automatic send(input logic [7:0] d, input logic stop, input int rden_at);
        for (int i = 0; i < FRAME_CLKS; i++) begin
            bus.rx    = frame_bit(d, stop, i);
            bus.rd_en = (i == rden_at);
            @(negedge clk);
        end
        bus.rx    = 1'b1;
        bus.rd_en = 1'b0;
    endtask

    task automatic do_read(input string name);
        bus.rd_en = 1'b1;
        @(negedge clk);
        bus.rd_en = 1'b0;
        chk({name, "_rdy_after_read"}, 32'(bus.rd_rdy), 32'(0));
    endtask

    int  fe0;
    int  ov0;
    logic seen_busy_low;

    initial begin
        total  = 0;
        bad    = 0;
        fe_cnt = 0;
        ov_cnt = 0;
        rst    = 1'b1;
        bus.rx = 1'b1;
        bus.rd_en = 1'b0;

        vec[0] = '{8'h55, 1'b1, -1,  4, 8'h55, 1'b1, 0, 0, 1'b1};
        vec[1] = '{8'h12, 1'b1, -1,  0, 8'h12, 1'b1, 0, 0, 1'b0};
        vec[2] = '{8'h34, 1'b1, -1,  4, 8'h12, 1'b1, 0, 1, 1'b1};
        vec[3] = '{8'h12, 1'b1, -1,  0, 8'h12, 1'b1, 0, 0, 1'b0};
        vec[4] = '{8'h34, 1'b1, 154, 4, 8'h34, 1'b1, 0, 0, 1'b1};
        vec[5] = '{8'h99, 1'b1, -1,  0, 8'h99, 1'b1, 0, 0, 1'b0};
        vec[6] = '{8'hA5, 1'b0, -1,  8, 8'h99, 1'b1, 1, 0, 1'b1};
        vec[7] = '{8'hC3, 1'b1, -1,  4, 8'hC3, 1'b1, 0, 0, 1'b0};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_dout", 32'(bus.dout), 32'(0));
        chk("rst_rdy", 32'(bus.rd_rdy), 32'(0));
        chk("rst_fe", 32'(bus.frame_err), 32'(0));
        chk("rst_ov", 32'(bus.overrun), 32'(0));
        chk("rst_busy", 32'(bus.busy), 32'(0));
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_busy", 32'(bus.busy), 32'(0));

        // False start: 3-clk glitch
        fe0 = fe_cnt;
        bus.rx = 1'b0;
        repeat (3) @(negedge clk);
        bus.rx = 1'b1;
        chk("glitch_busy_hi", 32'(bus.busy), 32'(1));
        seen_busy_low = 1'b0;
        for (int k = 0; k < 9 && !seen_busy_low; k++) begin
            @(negedge clk);
            if (bus.busy === 1'b0) seen_busy_low = 1'b1;
        end
        chk("glitch_busy_lo", 32'(seen_busy_low), 32'(1));
        chk("glitch_rdy", 32'(bus.rd_rdy), 32'(0));
        chk("glitch_fe", 32'(fe_cnt - fe0), 32'(0));
        repeat (20) @(negedge clk);

        // Low stop bit followed by a held-low break
        fe0 = fe_cnt;
        for (int i = 0; i < FRAME_CLKS; i++) begin
            bus.rx = frame_bit(8'hA5, 1'b0, i);
            @(negedge clk);
        end
        bus.rx = 1'b0;
        repeat (40) @(negedge clk);
        chk("break_busy", 32'(bus.busy), 32'(1));
        chk("break_rdy", 32'(bus.rd_rdy), 32'(0));
        chk("break_fe", 32'(fe_cnt - fe0), 32'(1));
        bus.rx = 1'b1;
        repeat (6) @(negedge clk);
        chk("break_release_busy", 32'(bus.busy), 32'(0));
        send(8'h3C, 1'b1, -1);
        repeat (4) @(negedge clk);
        chk("after_break_dout", 32'(bus.dout), 32'(8'h3C));
        chk("after_break_rdy", 32'(bus.rd_rdy), 32'(1));
        chk("after_break_fe", 32'(fe_cnt - fe0), 32'(1));
        do_read("after_break");
        repeat (4) @(negedge clk);

        // Frame table
        for (int r = 0; r < NV; r++) begin
            fe0 = fe_cnt;
            ov0 = ov_cnt;
            send(vec[r].data, vec[r].stop, vec[r].rden_at);
            repeat (vec[r].gap) @(negedge clk);
            chk($sformatf("v%0d_dout", r), 32'(bus.dout), 32'(vec[r].exp_dout));
            chk($sformatf("v%0d_rdy", r), 32'(bus.rd_rdy), 32'(vec[r].exp_rdy));
            chk($sformatf("v%0d_fe", r), 32'(fe_cnt - fe0), 32'(vec[r].exp_fe));
            chk($sformatf("v%0d_ov", r), 32'(ov_cnt - ov0), 32'(vec[r].exp_ov));
            chk($sformatf("v%0d_busy", r), 32'(bus.busy), 32'(0));
            if (vec[r].do_read) do_read($sformatf("v%0d", r));
        end

        // Reset during data bit 4 with an unread byte pending
        chk("prerst_rdy", 32'(bus.rd_rdy), 32'(1));
        for (int i = 0; i < 88; i++) begin
            bus.rx = frame_bit(8'h00, 1'b1, i);
            @(negedge clk);
        end
        chk("midframe_busy", 32'(bus.busy), 32'(1));
        rst    = 1'b1;
        bus.rx = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_dout", 32'(bus.dout), 32'(0));
        chk("midrst_rdy", 32'(bus.rd_rdy), 32'(0));
        chk("midrst_fe", 32'(bus.frame_err), 32'(0));
        chk("midrst_ov", 32'(bus.overrun), 32'(0));
        chk("midrst_busy", 32'(bus.busy), 32'(0));
        repeat (20) @(negedge clk);
        chk("midrst_no_partial", 32'(bus.rd_rdy), 32'(0));
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        send(8'h7E, 1'b1, -1);
        repeat (4) @(negedge clk);
        chk("postrst_dout", 32'(bus.dout), 32'(8'h7E));
        chk("postrst_rdy", 32'(bus.rd_rdy), 32'(1));
        chk("postrst_fe", 32'(fe_cnt - fe0), 32'(0));
        chk("postrst_ov", 32'(ov_cnt - ov0), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
